// File: rtl/tx_fifo_ctrl_module.sv
// Byte FIFO feeding the UART TX control stage: buffers user bytes and presents one per frame on TX_En_Sig/TX_Data.
// Optional build macro TX_FIFO_OVERFLOW_FLAG_EN adds a sticky overflow flag (Clr_Ovf / Overflow_Sig).
module tx_fifo_ctrl_module #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  CLOCK,
    input  logic                  RST_n,
    input  logic                  Wr_Req,
    input  logic [DATA_W-1:0]     Wr_Data,
    output logic                  Full_Sig,
    output logic                  Empty_Sig,
    output logic [DEPTH_LOG2:0]   Level,
    input  logic                  TX_Done_Sig,
    output logic                  TX_En_Sig,
    output logic [DATA_W-1:0]     TX_Data,
    output logic                  Busy_Sig
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
    ,
    input  logic                  Clr_Ovf,
    output logic                  Overflow_Sig
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2:0]   wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0]   rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_reg, level_next;
    logic                  full_reg, empty_reg;
    logic [DATA_W-1:0]     tx_data_reg;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  wr_en, pop;

    assign wr_en = Wr_Req && !full_reg;

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A pop loads the next frame byte; SEND only ends when Done arrives with nothing queued.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (TX_Done_Sig) begin
                    if (!empty_reg) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    assign wr_ptr_next = wr_ptr_reg + {{DEPTH_LOG2{1'b0}}, wr_en};
    assign rd_ptr_next = rd_ptr_reg + {{DEPTH_LOG2{1'b0}}, pop};
    assign level_next  = wr_ptr_next - rd_ptr_next;

    // Flags are derived from the post-edge pointers so they are exact right after each edge.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            empty_reg  <= (wr_ptr_next == rd_ptr_next);
            full_reg   <= (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                          (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= Wr_Data;
        end
    end

`ifdef TX_FIFO_OVERFLOW_FLAG_EN
    logic ovf_reg;

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            ovf_reg <= 1'b0;
        end else if (Clr_Ovf) begin
            ovf_reg <= 1'b0;
        end else if (Wr_Req && full_reg) begin
            ovf_reg <= 1'b1;
        end
    end

    assign Overflow_Sig = ovf_reg;
`endif

    assign Full_Sig  = full_reg;
    assign Empty_Sig = empty_reg;
    assign Level     = level_reg;
    assign TX_En_Sig = (state_reg == SEND);
    assign TX_Data   = tx_data_reg;
    assign Busy_Sig  = TX_En_Sig || !empty_reg;

endmodule

// File: tb/tb_tx_fifo_ctrl_module.sv
// Self-checking bench for tx_fifo_ctrl_module: directed scenarios plus random traffic against a queue model.
module tb_tx_fifo_ctrl_module;

    logic       CLOCK = 1'b0;
    logic       RST_n = 1'b0;
    logic       Wr_Req = 1'b0;
    logic [7:0] Wr_Data = 8'h00;
    logic       TX_Done_Sig = 1'b0;
    logic       Clr_Ovf = 1'b0;
    logic       Full_Sig, Empty_Sig, TX_En_Sig, Busy_Sig;
    logic [4:0] Level;
    logic [7:0] TX_Data;
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
    logic       Overflow_Sig;
`endif

    tx_fifo_ctrl_module #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .CLOCK(CLOCK), .RST_n(RST_n), .Wr_Req(Wr_Req), .Wr_Data(Wr_Data),
        .Full_Sig(Full_Sig), .Empty_Sig(Empty_Sig), .Level(Level),
        .TX_Done_Sig(TX_Done_Sig), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .Busy_Sig(Busy_Sig)
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
        , .Clr_Ovf(Clr_Ovf), .Overflow_Sig(Overflow_Sig)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: a byte queue, the byte being sent, and whether a frame is in progress.
    logic [7:0] m_q[$];
    bit         m_en;
    logic [7:0] m_data;
    bit         m_ovf;
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_en   = 0;
        m_data = 8'h00;
        m_ovf  = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d, input bit done, input bit clr);
        int  sz;
        bit  full, empty;
        sz    = m_q.size();
        full  = (sz == 16);
        empty = (sz == 0);
        if (!empty && (!m_en || done)) begin
            m_data = m_q.pop_front();
            m_en   = 1;
        end else if (m_en && done) begin
            m_en = 0;
        end
        if (wr && !full) m_q.push_back(d);
        if (clr) m_ovf = 0;
        else if (wr && full) m_ovf = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".en"},    TX_En_Sig, m_en);
        chk({tag, ".data"},  TX_Data,   m_data);
        chk({tag, ".level"}, Level,     m_q.size());
        chk({tag, ".empty"}, Empty_Sig, m_q.size() == 0);
        chk({tag, ".full"},  Full_Sig,  m_q.size() == 16);
        chk({tag, ".busy"},  Busy_Sig,  m_en || (m_q.size() != 0));
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
        chk({tag, ".ovf"},   Overflow_Sig, m_ovf);
`endif
    endtask

    task automatic step(input string tag, input bit wr, input logic [7:0] d, input bit done, input bit clr);
        Wr_Req      = wr;
        Wr_Data     = d;
        TX_Done_Sig = done;
        Clr_Ovf     = clr;
        @(posedge CLOCK);
        model_edge(wr, d, done, clr);
        #1;
        Wr_Req      = 1'b0;
        TX_Done_Sig = 1'b0;
        Clr_Ovf     = 1'b0;
        $display("%s: wr=%0b d=%02h done=%0b -> en=%0b data=%02h level=%0d", tag, wr, d, done,
                 TX_En_Sig, TX_Data, Level);
        check_all(tag);
    endtask

    // Pulses Done every other cycle until model is idle and empty; bounded.
    task automatic drain(input string tag);
        for (int i = 0; i < 80 && (m_en || m_q.size() != 0); i++) begin
            step(tag, 0, 8'h00, (i % 2 == 1) && m_en, 0);
        end
        chk({tag, ".drained"}, TX_En_Sig, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".en"},    TX_En_Sig, 1'b0);
        chk({tag, ".data"},  TX_Data,   8'h00);
        chk({tag, ".empty"}, Empty_Sig, 1'b1);
        chk({tag, ".full"},  Full_Sig,  1'b0);
        chk({tag, ".level"}, Level,     5'd0);
        chk({tag, ".busy"},  Busy_Sig,  1'b0);
    endtask

    initial begin
        bit prev_done;
        bit wr, done;
        model_reset();

        // Reset held low
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_values("t1_reset");
        #2 RST_n = 1'b1;
        @(posedge CLOCK);
        #1;

        // Single byte
        step("t2_wr", 1, 8'h55, 0, 0);
        chk("t2_not_yet", TX_En_Sig, 1'b0);
        step("t2_pop", 0, 8'h00, 0, 0);
        chk("t2_data", TX_Data, 8'h55);
        chk("t2_en", TX_En_Sig, 1'b1);
        repeat (3) step("t2_hold", 0, 8'h00, 0, 0);
        step("t2_done", 0, 8'h00, 1, 0);
        chk("t2_en_off", TX_En_Sig, 1'b0);
        chk("t2_empty", Empty_Sig, 1'b1);

        // Back-to-back frames
        step("t3_wr", 1, 8'hA1, 0, 0);
        step("t3_wr", 1, 8'hB2, 0, 0);
        step("t3_wr", 1, 8'hC3, 0, 0);
        chk("t3_first", TX_Data, 8'hA1);
        step("t3_hold", 0, 8'h00, 0, 0);
        step("t3_done1", 0, 8'h00, 1, 0);
        chk("t3_second", TX_Data, 8'hB2);
        step("t3_hold", 0, 8'h00, 0, 0);
        step("t3_done2", 0, 8'h00, 1, 0);
        chk("t3_third", TX_Data, 8'hC3);
        chk("t3_en", TX_En_Sig, 1'b1);
        step("t3_done3", 0, 8'h00, 1, 0);
        chk("t3_en_off", TX_En_Sig, 1'b0);

        // Fill while stalled
        for (int i = 0; i < 18; i++) step("t4_fill", 1, 8'(i), 0, 0);
        chk("t4_level", Level, 5'd16);
        chk("t4_full", Full_Sig, 1'b1);
        chk("t4_cur", TX_Data, 8'h00);
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
        chk("t4_ovf", Overflow_Sig, 1'b1);
        step("t4_hold", 0, 8'h00, 0, 0);
        chk("t4_ovf_sticky", Overflow_Sig, 1'b1);
        step("t4_clr", 1, 8'hEE, 0, 1);
        chk("t4_ovf_clr", Overflow_Sig, 1'b0);
`endif
        drain("t4_drain");

        // Write coincident with pop
        step("t5_wr", 1, 8'h11, 0, 0);
        step("t5_wr", 1, 8'h22, 0, 0);
        chk("t5_level1", Level, 5'd1);
        step("t5_both", 1, 8'h33, 1, 0);
        chk("t5_level", Level, 5'd1);
        chk("t5_data", TX_Data, 8'h22);
        drain("t5_drain");

        // Async reset mid-frame
        for (int i = 0; i < 6; i++) step("t6_fill", 1, 8'h80 + 8'(i), 0, 0);
        chk("t6_level5", Level, 5'd5);
        chk("t6_en", TX_En_Sig, 1'b1);
        #2 RST_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("t6_async");
        @(posedge CLOCK);
        #2 RST_n = 1'b1;
        for (int i = 0; i < 3; i++) step("t6_idle", 0, 8'h00, 0, 0);
        step("t6_wr", 1, 8'h3C, 0, 0);
        step("t6_pop", 0, 8'h00, 0, 0);
        chk("t6_new", TX_Data, 8'h3C);
        drain("t6_drain");

        // Random traffic: a write-heavy phase then a drain-heavy phase
        prev_done = 0;
        for (int i = 0; i < 400; i++) begin
            wr   = ($urandom_range(0, 99) < ((i < 200) ? 80 : 30));
            done = m_en && !prev_done && ($urandom_range(0, 99) < ((i < 200) ? 20 : 60));
            step("rnd", wr, 8'($urandom), done, ($urandom_range(0, 31) == 0));
            prev_done = done;
        end
        drain("rnd_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
